// File: rtl/microfluidic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// microfluidic_ctrl_pkg
//
// Shared types and constants for the mixing-network fan-out controller.
//   state_t        : controller FSM states (IDLE, OPEN, PUMP, CLOSE, DONE)
//   PUMP_IDLE      : pump valve pattern with every valve closed
//   PHASE_P0/P1/P2 : peristaltic rotation patterns (1 = valve closed)
//   outlet_t       : outlet index; ILLEGAL_OUTLET is the unused code 3
//   outlet_onehot  : outlet index -> one-hot outlet valve vector
//   pump_pattern   : phase index (0..2) -> pump valve pattern
// ---------------------------------------------------------------------------
package microfluidic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OPEN  = 3'd1,
        PUMP  = 3'd2,
        CLOSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] PUMP_IDLE = 3'b111;
    localparam logic [2:0] PHASE_P0  = 3'b011;
    localparam logic [2:0] PHASE_P1  = 3'b101;
    localparam logic [2:0] PHASE_P2  = 3'b110;

    typedef logic [1:0] outlet_t;
    localparam outlet_t ILLEGAL_OUTLET = 2'd3;

    // Code 3 yields 000; callers never open a valve for the illegal code.
    function automatic logic [2:0] outlet_onehot(input outlet_t idx);
        logic [2:0] vec;
        vec = 3'b000;
        case (idx)
            2'd0:    vec = 3'b001;
            2'd1:    vec = 3'b010;
            2'd2:    vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

    function automatic logic [2:0] pump_pattern(input logic [1:0] phase_idx);
        logic [2:0] pat;
        pat = PUMP_IDLE;
        case (phase_idx)
            2'd0:    pat = PHASE_P0;
            2'd1:    pat = PHASE_P1;
            2'd2:    pat = PHASE_P2;
            default: pat = PUMP_IDLE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/peristaltic_phase_seq.sv
// ---------------------------------------------------------------------------
// peristaltic_phase_seq
//
// Three-phase peristaltic pump sequencer. While enabled it rotates
// P0 -> P1 -> P2 -> P0 ..., holding each phase PHASE_CYC cycles. step_tick
// is high during the final cycle of P2, i.e. the cycle that completes one
// full pump step. When disabled the pump is parked (all valves closed) and
// the sequencer restarts from the beginning of P0 on the next enable.
//
// Parameters:
//   PHASE_CYC  : cycles each phase is held (>= 1)
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   enable     : run the rotation
//   phase_out  : pump valve pattern (1 = valve closed)
//   step_tick  : last cycle of a complete P0/P1/P2 step
// ---------------------------------------------------------------------------
module peristaltic_phase_seq
    import microfluidic_ctrl_pkg::*;
#(
    parameter int PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [2:0] phase_out,
    output logic       step_tick
);

    localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PHASE_CYC - 1);

    logic [CNT_W-1:0] hold_cnt_reg;
    logic [1:0]       phase_idx_reg;
    logic             phase_end;

    assign phase_end = (hold_cnt_reg == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg  <= '0;
            phase_idx_reg <= 2'd0;
        end else if (!enable) begin
            hold_cnt_reg  <= '0;
            phase_idx_reg <= 2'd0;
        end else if (phase_end) begin
            hold_cnt_reg  <= '0;
            phase_idx_reg <= (phase_idx_reg == 2'd2) ? 2'd0 : phase_idx_reg + 2'd1;
        end else begin
            hold_cnt_reg  <= hold_cnt_reg + CNT_W'(1);
        end
    end

    assign step_tick = enable && phase_end && (phase_idx_reg == 2'd2);
    assign phase_out = enable ? pump_pattern(phase_idx_reg) : PUMP_IDLE;

endmodule

// File: rtl/three_outlet_splitter_ctrl.sv
// ---------------------------------------------------------------------------
// three_outlet_splitter_ctrl
//
// Fan-out controller for the mixing network. A metered source stream is
// routed to one of three outlets by opening a one-hot outlet valve and
// pumping a commanded number of peristaltic steps:
//   IDLE -> OPEN (valve settle) -> PUMP (steps) -> CLOSE (valve settle)
//        -> DONE (one-cycle completion/error pulse) -> IDLE
// Illegal commands (outlet 3 or zero steps) are accepted but only produce
// err_pulse on the following cycle; no valve moves. abort in OPEN or PUMP
// jumps to CLOSE, which always runs its full settle time, and DONE then
// reports err_pulse instead of done_pulse.
//
// Optional build macro: SPLITTER_VOLUME_LOG_EN adds per-outlet saturating
// 16-bit counters of completed pump steps (vol_total0/1/2).
//
// Parameters:
//   STEP_W     : width of cmd_steps
//   PHASE_CYC  : cycles each pump phase is held (>= 1)
//   SETTLE_CYC : valve settle cycles after open and after close (>= 1)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_outlet, cmd_steps : command fields, latched on acceptance
//   abort                 : early termination request (OPEN/PUMP only)
//   valve_out             : one-hot outlet valve, bit n = outlet n
//   pump_phase            : pump valve pattern, 1 = closed
//   busy                  : any state other than IDLE
//   done_pulse, err_pulse : single-cycle completion / error indications
//   vol_total0/1/2        : (SPLITTER_VOLUME_LOG_EN) step totals per outlet
// ---------------------------------------------------------------------------
module three_outlet_splitter_ctrl
    import microfluidic_ctrl_pkg::*;
#(
    parameter int STEP_W     = 8,
    parameter int PHASE_CYC  = 4,
    parameter int SETTLE_CYC = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_outlet,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic [2:0]        valve_out,
    output logic [2:0]        pump_phase,
    output logic              busy,
    output logic              done_pulse,
`ifdef SPLITTER_VOLUME_LOG_EN
    output logic              err_pulse,
    output logic [15:0]       vol_total0,
    output logic [15:0]       vol_total1,
    output logic [15:0]       vol_total2
`else
    output logic              err_pulse
`endif
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    state_t            state_reg;
    state_t            state_next;
    outlet_t           outlet_reg;
    logic [STEP_W-1:0] steps_reg;
    logic [SET_W-1:0]  settle_cnt_reg;
    logic              aborted_reg;
    logic              illegal_err_reg;

    logic              accept;
    logic              cmd_legal;
    logic              settle_end;
    logic              pump_en;
    logic              step_tick;
    logic              last_step;
    logic              abort_window;
    logic [2:0]        seq_phase;

    assign accept       = cmd_valid && (state_reg == IDLE);
    assign cmd_legal    = (cmd_outlet != ILLEGAL_OUTLET) && (cmd_steps != '0);
    assign settle_end   = (settle_cnt_reg == SETTLE_LAST);
    assign pump_en      = (state_reg == PUMP);
    assign last_step    = step_tick && (steps_reg == STEP_W'(1));
    assign abort_window = (state_reg == OPEN) || (state_reg == PUMP);

    // The sequencer only runs in PUMP, where an outlet valve is always open,
    // so the pump is never driven against a fully closed outlet manifold.
    peristaltic_phase_seq #(
        .PHASE_CYC (PHASE_CYC)
    ) u_phase_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (pump_en),
        .phase_out (seq_phase),
        .step_tick (step_tick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // abort takes priority over both the OPEN settle expiry and the final
    // pump step, so a coincident abort is always reported as an error.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && cmd_legal) begin
                    state_next = OPEN;
                end
            end
            OPEN: begin
                if (abort) begin
                    state_next = CLOSE;
                end else if (settle_end) begin
                    state_next = PUMP;
                end
            end
            PUMP: begin
                if (abort || last_step) begin
                    state_next = CLOSE;
                end
            end
            CLOSE: begin
                if (settle_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // Decoded from the state register so an asynchronous reset parks the
    // valves and pump immediately, with no pulse.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready  = 1'b0;
        valve_out  = 3'b000;
        pump_phase = PUMP_IDLE;
        busy       = 1'b1;
        done_pulse = 1'b0;
        err_pulse  = illegal_err_reg;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            OPEN: begin
                valve_out = outlet_onehot(outlet_reg);
            end
            PUMP: begin
                valve_out  = outlet_onehot(outlet_reg);
                pump_phase = seq_phase;
            end
            CLOSE: begin
                valve_out = 3'b000;
            end
            DONE: begin
                done_pulse = !aborted_reg;
                err_pulse  = aborted_reg;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command latch, settle timer, step counter, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outlet_reg      <= 2'd0;
            steps_reg       <= '0;
            settle_cnt_reg  <= '0;
            aborted_reg     <= 1'b0;
            illegal_err_reg <= 1'b0;
        end else begin
            // Illegal commands only raise a one-cycle error flag.
            illegal_err_reg <= accept && !cmd_legal;

            if (accept && cmd_legal) begin
                outlet_reg <= cmd_outlet;
                steps_reg  <= cmd_steps;
            end else if (step_tick && (steps_reg != '0)) begin
                // Count down; guarded so the counter can never wrap.
                steps_reg <= steps_reg - STEP_W'(1);
            end

            if (accept) begin
                aborted_reg <= 1'b0;
            end else if (abort_window && abort) begin
                aborted_reg <= 1'b1;
            end

            // Settle timer restarts on every state change.
            if (state_next != state_reg) begin
                settle_cnt_reg <= '0;
            end else if ((state_reg == OPEN) || (state_reg == CLOSE)) begin
                settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
            end
        end
    end

`ifdef SPLITTER_VOLUME_LOG_EN
    // ------------------------------------------------------------------
    // Per-outlet completed-step totals, saturating at 0xFFFF. A step that
    // completes in the same cycle as an abort has been fully pumped and
    // is therefore counted.
    // ------------------------------------------------------------------
    logic [15:0] vol_reg [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_vol
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vol_reg[gi] <= 16'h0000;
            end else if (step_tick && (outlet_reg == outlet_t'(gi))
                         && (vol_reg[gi] != 16'hFFFF)) begin
                vol_reg[gi] <= vol_reg[gi] + 16'd1;
            end
        end
    end

    assign vol_total0 = vol_reg[0];
    assign vol_total1 = vol_reg[1];
    assign vol_total2 = vol_reg[2];
`endif

endmodule

// File: tb/tb_three_outlet_splitter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_three_outlet_splitter_ctrl
//
// Directed bench for three_outlet_splitter_ctrl (STEP_W=8, PHASE_CYC=4,
// SETTLE_CYC=10). Cycle k is the clock period that starts k rising edges
// after the accepting edge; all outputs are sampled 1 time unit after the
// rising edge. Observed outputs are packed as
// {cmd_ready, valve_out, pump_phase, busy, done_pulse, err_pulse}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_three_outlet_splitter_ctrl;

    localparam int STEP_W = 8;
    localparam int PHASE  = 4;
    localparam int SETTLE = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_outlet;
    logic [STEP_W-1:0] cmd_steps;
    logic              abort;
    logic [2:0]        valve_out;
    logic [2:0]        pump_phase;
    logic              busy;
    logic              done_pulse;
    logic              err_pulse;
`ifdef SPLITTER_VOLUME_LOG_EN
    logic [15:0]       vol_total0;
    logic [15:0]       vol_total1;
    logic [15:0]       vol_total2;
`endif

    int checks = 0;
    int errors = 0;

    logic [9:0] obs;
    assign obs = {cmd_ready, valve_out, pump_phase, busy, done_pulse, err_pulse};

    localparam logic [9:0] IDLE_VEC = 10'b1_000_111_0_0_0;

    always #5 clk = ~clk;

    three_outlet_splitter_ctrl #(
        .STEP_W     (STEP_W),
        .PHASE_CYC  (PHASE),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_outlet (cmd_outlet),
        .cmd_steps  (cmd_steps),
        .abort      (abort),
        .valve_out  (valve_out),
        .pump_phase (pump_phase),
        .busy       (busy),
        .done_pulse (done_pulse),
`ifdef SPLITTER_VOLUME_LOG_EN
        .err_pulse  (err_pulse),
        .vol_total0 (vol_total0),
        .vol_total1 (vol_total1),
        .vol_total2 (vol_total2)
`else
        .err_pulse  (err_pulse)
`endif
    );

    // Expected output vector in cycle k of a legal run. abort_at > 0 means
    // abort is held high during cycle abort_at (sampled at its closing edge).
    function automatic logic [9:0] exp_vec(input int k, input int outlet,
                                           input int steps, input int abort_at);
        int         cs;
        logic [2:0] v;
        logic [2:0] p;
        logic [2:0] onehot;
        logic       rdy, bsy, dn, er;
        onehot = 3'b001;
        cs  = (abort_at > 0) ? abort_at + 1 : SETTLE + 3 * PHASE * steps + 1;
        v   = 3'b000;
        p   = 3'b111;
        rdy = 1'b0;
        bsy = 1'b1;
        dn  = 1'b0;
        er  = 1'b0;
        if (k < cs) v = onehot << outlet;
        if (k > SETTLE && k < cs) begin
            case (((k - SETTLE - 1) / PHASE) % 3)
                0:       p = 3'b011;
                1:       p = 3'b101;
                default: p = 3'b110;
            endcase
        end
        if (k == cs + SETTLE) begin
            if (abort_at > 0) er = 1'b1;
            else              dn = 1'b1;
        end
        if (k > cs + SETTLE) begin
            rdy = 1'b1;
            bsy = 1'b0;
        end
        return {rdy, v, p, bsy, dn, er};
    endfunction

    // Presents a command and returns 1 time unit after the accepting edge.
    task automatic issue(input logic [1:0] outlet, input int steps, input logic keep_valid);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_outlet = outlet;
        cmd_steps  = STEP_W'(steps);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready outlet=%0d got %b expected 1", outlet, cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = keep_valid;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_outlet = 2'd0;
        cmd_steps  = '0;
        abort      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_state got %b expected %b", obs, IDLE_VEC);
        end
`ifdef SPLITTER_VOLUME_LOG_EN
        checks++;
        if ({vol_total0, vol_total1, vol_total2} !== 48'd0) begin
            errors++;
            $display("FAIL reset_vol got %h %h %h expected 0", vol_total0, vol_total1, vol_total2);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release got %b expected %b", obs, IDLE_VEC);
        end
        $display("test_reset: done");
    endtask

    task automatic test_legal(input logic [1:0] outlet, input int steps, input int abort_at);
        int n;
        n = SETTLE + 3 * PHASE * steps + SETTLE + 3;
        if (abort_at > 0) n = abort_at + SETTLE + 3;
        issue(outlet, steps, 1'b0);
        for (int k = 1; k <= n; k++) begin
            abort = (k == abort_at);
            checks++;
            if (obs !== exp_vec(k, outlet, steps, abort_at)) begin
                errors++;
                $display("FAIL run outlet=%0d steps=%0d abort_at=%0d cycle=%0d got %b expected %b",
                         outlet, steps, abort_at, k, obs, exp_vec(k, outlet, steps, abort_at));
            end
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        $display("test_legal: outlet=%0d steps=%0d abort_at=%0d cycles=%0d", outlet, steps, abort_at, n);
    endtask

    task automatic test_illegal(input logic [1:0] outlet, input int steps);
        logic [9:0] exp;
        issue(outlet, steps, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            exp = (k == 1) ? 10'b1_000_111_0_0_1 : IDLE_VEC;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL illegal outlet=%0d steps=%0d cycle=%0d got %b expected %b",
                         outlet, steps, k, obs, exp);
            end
            @(posedge clk);
            #1;
        end
        $display("test_illegal: outlet=%0d steps=%0d", outlet, steps);
    endtask

    task automatic test_back_to_back();
        issue(2'd0, 1, 1'b1);
        cmd_outlet = 2'd2;
        cmd_steps  = STEP_W'(1);
        // First run: DONE in cycle 33, second command accepted at the end of cycle 34.
        for (int k = 1; k <= 34; k++) begin
            checks++;
            if (obs !== exp_vec(k, 0, 1, 0)) begin
                errors++;
                $display("FAIL b2b_first cycle=%0d got %b expected %b", k, obs, exp_vec(k, 0, 1, 0));
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            checks++;
            if (obs !== exp_vec(k, 2, 1, 0)) begin
                errors++;
                $display("FAIL b2b_second cycle=%0d got %b expected %b", k, obs, exp_vec(k, 2, 1, 0));
            end
            @(posedge clk);
            #1;
        end
        $display("test_back_to_back: done");
    endtask

    task automatic test_reset_mid_pump();
        issue(2'd1, 2, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (obs !== exp_vec(15, 1, 2, 0)) begin
            errors++;
            $display("FAIL mid_pump_state got %b expected %b", obs, exp_vec(15, 1, 2, 0));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL async_reset got %b expected %b", obs, IDLE_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== IDLE_VEC) begin
                errors++;
                $display("FAIL after_reset cycle=%0d got %b expected %b", k, obs, IDLE_VEC);
            end
        end
        $display("test_reset_mid_pump: done");
    endtask

`ifdef SPLITTER_VOLUME_LOG_EN
    task automatic test_volume(input logic [15:0] exp2);
        checks++;
        if ({vol_total0, vol_total1, vol_total2} !== {16'd0, 16'd0, exp2}) begin
            errors++;
            $display("FAIL volume got %0d %0d %0d expected 0 0 %0d",
                     vol_total0, vol_total1, vol_total2, exp2);
        end
        $display("test_volume: vol_total2=%0d", vol_total2);
    endtask
`endif

    initial begin
        test_reset();
        test_legal(2'd1, 2, 0);            // done in cycle 45, ready in 46
        test_illegal(2'd3, 5);
        test_illegal(2'd1, 0);
        test_legal(2'd0, 3, 15);           // abort 5 cycles into PUMP
        test_legal(2'd0, 2, 3);            // abort during OPEN
        test_legal(2'd1, 1, 22);           // abort on the final pump cycle
        test_back_to_back();
        test_reset_mid_pump();             // also clears volume totals
        test_legal(2'd2, 255, 0);          // maximum step count
        test_legal(2'd2, 255, 0);
`ifdef SPLITTER_VOLUME_LOG_EN
        test_volume(16'd510);
`endif
        test_legal(2'd2, 3, 25);           // abort after one full step
`ifdef SPLITTER_VOLUME_LOG_EN
        test_volume(16'd511);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
